// File: rtl/palette_fade_ctrl.sv
// rtl/palette_fade_ctrl.sv - palette fade sequencer and CPU/engine port arbiter
module palette_fade_ctrl #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK_100,
  input  logic        RESET,
  input  logic [1:0]  AVL_ADDR,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA,
  input  logic        AVL_WRITE,
  input  logic        AVL_READ,
  input  logic        AVL_CS,
  input  logic [4:0]  CPU_ADDR,
  input  logic [31:0] CPU_WRITEDATA,
  input  logic [3:0]  CPU_BYTE_EN,
  input  logic        CPU_WRITE,
  input  logic        CPU_READ,
  output logic        CPU_WAITREQUEST,
  output logic [31:0] CPU_READDATA,
  output logic [4:0]  PAL_ADDR,
  output logic [31:0] PAL_WRITEDATA,
  output logic [3:0]  PAL_BYTE_EN,
  output logic        PAL_WRITE,
  output logic        PAL_READ,
  output logic        PAL_CS,
  input  logic [31:0] PAL_READDATA,
  input  logic        VSYNC,
  output logic        IRQ
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_WR, S_FIN} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        state, state_nx;
  logic          ctrl_en;
  logic [2:0]    ctrl_sel;
  logic [7:0]    ctrl_step;
  logic [7:0]    frames;
  logic          done, pending, vsync_d;
  logic [2:0]    sh_sel;
  logic [7:0]    sh_step;
  logic [1:0]    idx;
  logic [31:0]   rd_data;
  logic [SW-1:0] starve_cnt;
  logic          cpu_wr, cpu_rd, cpu_req, forced, eng_grant;
  logic          csr_wr, csr_rd, vsync_rise, pass_start, fin;
  logic [7:0]    frames_dec;
  logic [31:0]   faded;
  logic          unused_bits;

  function automatic logic [7:0] sat_sub(input logic [7:0] c, input logic [7:0] s);
    return (c > s) ? (c - s) : 8'h00;
  endfunction

  // CPU strobes are masked during reset so nothing reaches the palette while RESET is high
  assign cpu_wr     = CPU_WRITE & ~RESET;
  assign cpu_rd     = CPU_READ & ~CPU_WRITE & ~RESET;
  assign cpu_req    = cpu_wr | cpu_rd;
  assign forced     = (starve_cnt >= STARVE_MAX);
  assign csr_wr     = AVL_CS & AVL_WRITE;
  assign csr_rd     = AVL_CS & AVL_READ;
  assign vsync_rise = VSYNC & ~vsync_d;
  assign pass_start = (state == S_IDLE) && pending && ctrl_en;
  assign fin        = (state == S_FIN);
  assign frames_dec = (frames != 8'd0) ? (frames - 8'd1) : 8'd0;
  assign faded      = {8'h00, sat_sub(rd_data[23:16], sh_step),
                       sat_sub(rd_data[15:8], sh_step), sat_sub(rd_data[7:0], sh_step)};
  assign PAL_CS       = PAL_WRITE | PAL_READ;
  assign CPU_READDATA = PAL_READDATA;
  assign IRQ          = done;
  assign unused_bits  = ^{AVL_WRITEDATA[31:16], rd_data[31:24]};

  // State register
  always_ff @(posedge CLK_100 or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and palette port mux: CPU passes through unless the engine holds the port
  always_comb begin
    state_nx        = state;
    eng_grant       = 1'b0;
    CPU_WAITREQUEST = 1'b0;
    PAL_ADDR        = CPU_ADDR;
    PAL_WRITEDATA   = CPU_WRITEDATA;
    PAL_BYTE_EN     = CPU_BYTE_EN;
    PAL_WRITE       = cpu_wr;
    PAL_READ        = cpu_rd;
    case (state)
      S_IDLE: if (pass_start) state_nx = S_RD;
      S_RD: begin
        if (!cpu_req || forced) begin
          eng_grant       = 1'b1;
          state_nx        = S_WT;
          CPU_WAITREQUEST = 1'b1;
          PAL_ADDR        = {sh_sel, idx};
          PAL_WRITEDATA   = 32'h0;
          PAL_BYTE_EN     = 4'b1111;
          PAL_WRITE       = 1'b0;
          PAL_READ        = 1'b1;
        end
      end
      S_WT: begin
        state_nx        = S_WR;
        CPU_WAITREQUEST = 1'b1;
        PAL_ADDR        = {sh_sel, idx};
        PAL_WRITEDATA   = 32'h0;
        PAL_BYTE_EN     = 4'b0000;
        PAL_WRITE       = 1'b0;
        PAL_READ        = 1'b0;
      end
      S_WR: begin
        state_nx        = (idx == 2'd3) ? S_FIN : S_RD;
        CPU_WAITREQUEST = 1'b1;
        PAL_ADDR        = {sh_sel, idx};
        PAL_WRITEDATA   = faded;
        PAL_BYTE_EN     = 4'b0111;
        PAL_WRITE       = 1'b1;
        PAL_READ        = 1'b0;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Engine datapath: shadow CTRL at pass start, count starvation, capture entry, advance index
  always_ff @(posedge CLK_100 or posedge RESET) begin
    if (RESET) begin
      sh_sel     <= 3'd0;
      sh_step    <= 8'd0;
      idx        <= 2'd0;
      rd_data    <= 32'h0;
      starve_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (pass_start) begin
          sh_sel     <= ctrl_sel;
          sh_step    <= ctrl_step;
          idx        <= 2'd0;
          starve_cnt <= '0;
        end
        S_RD: begin
          if (eng_grant) starve_cnt <= '0;
          else           starve_cnt <= starve_cnt + 1'b1;
        end
        S_WT:    rd_data <= PAL_READDATA;
        S_WR:    idx <= idx + 2'd1;
        default: ;
      endcase
    end
  end

  // CSR file, VSYNC edge trigger and done/FRAMES bookkeeping
  always_ff @(posedge CLK_100 or posedge RESET) begin
    if (RESET) begin
      ctrl_en      <= 1'b0;
      ctrl_sel     <= 3'd0;
      ctrl_step    <= 8'd0;
      frames       <= 8'd0;
      done         <= 1'b0;
      pending      <= 1'b0;
      vsync_d      <= 1'b0;
      AVL_READDATA <= 32'h0;
    end else begin
      vsync_d <= VSYNC;
      if (pass_start) pending <= 1'b0;
      else if (vsync_rise && ctrl_en && frames != 8'd0) pending <= 1'b1;
      if (csr_wr && AVL_ADDR == 2'd0) begin
        ctrl_en   <= AVL_WRITEDATA[0];
        ctrl_sel  <= AVL_WRITEDATA[4:2];
        ctrl_step <= AVL_WRITEDATA[15:8];
      end
      if (csr_wr && AVL_ADDR == 2'd1) frames <= AVL_WRITEDATA[7:0];
      else if (fin)                   frames <= frames_dec;
      if (fin && frames_dec == 8'd0) done <= 1'b1;
      else if (csr_wr && AVL_ADDR == 2'd2 && AVL_WRITEDATA[1]) done <= 1'b0;
      if (csr_rd) begin
        case (AVL_ADDR)
          2'd0:    AVL_READDATA <= {16'h0, ctrl_step, 3'b0, ctrl_sel, 1'b0, ctrl_en};
          2'd1:    AVL_READDATA <= {24'h0, frames};
          2'd2:    AVL_READDATA <= {29'h0, pending, done, (state != S_IDLE)};
          default: AVL_READDATA <= 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// tb/tb_palette_fade_ctrl.sv - self-checking bench for palette_fade_ctrl
module tb_palette_fade_ctrl;

  logic        CLK_100 = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;
  logic        AVL_WRITE, AVL_READ, AVL_CS;
  logic [4:0]  CPU_ADDR;
  logic [31:0] CPU_WRITEDATA;
  logic [3:0]  CPU_BYTE_EN;
  logic        CPU_WRITE, CPU_READ;
  logic        CPU_WAITREQUEST;
  logic [31:0] CPU_READDATA;
  logic [4:0]  PAL_ADDR;
  logic [31:0] PAL_WRITEDATA;
  logic [3:0]  PAL_BYTE_EN;
  logic        PAL_WRITE, PAL_READ, PAL_CS;
  logic [31:0] PAL_READDATA = 32'h0;
  logic        VSYNC;
  logic        IRQ;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int eng_wr_cnt = 0;
  int wr_cycs[$];
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;
  logic [31:0] pal_mem [0:31];
  logic [31:0] model [0:31];

  palette_fade_ctrl #(.STARVE_LIMIT(4)) dut (
    .CLK_100(CLK_100), .RESET(RESET),
    .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .AVL_WRITE(AVL_WRITE), .AVL_READ(AVL_READ), .AVL_CS(AVL_CS),
    .CPU_ADDR(CPU_ADDR), .CPU_WRITEDATA(CPU_WRITEDATA), .CPU_BYTE_EN(CPU_BYTE_EN),
    .CPU_WRITE(CPU_WRITE), .CPU_READ(CPU_READ), .CPU_WAITREQUEST(CPU_WAITREQUEST),
    .CPU_READDATA(CPU_READDATA),
    .PAL_ADDR(PAL_ADDR), .PAL_WRITEDATA(PAL_WRITEDATA), .PAL_BYTE_EN(PAL_BYTE_EN),
    .PAL_WRITE(PAL_WRITE), .PAL_READ(PAL_READ), .PAL_CS(PAL_CS),
    .PAL_READDATA(PAL_READDATA), .VSYNC(VSYNC), .IRQ(IRQ)
  );

  always #5 CLK_100 = ~CLK_100;

  always @(posedge CLK_100) cyc <= cyc + 1;

  // palette register file: byte-enabled writes, read data one cycle after PAL_READ
  always @(posedge CLK_100) begin
    if (PAL_CS && PAL_WRITE)
      for (int b = 0; b < 4; b++)
        if (PAL_BYTE_EN[b]) pal_mem[PAL_ADDR][b*8 +: 8] <= PAL_WRITEDATA[b*8 +: 8];
    if (PAL_CS && PAL_READ) PAL_READDATA <= pal_mem[PAL_ADDR];
  end

  // scoreboard: every engine write is popped against the expected queue
  always @(negedge CLK_100) begin
    if (PAL_WRITE && PAL_BYTE_EN == 4'b0111) begin
      checks++;
      eng_wr_cnt++;
      wr_cycs.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL eng_write unexpected: addr=%0d data=%08h required no write", PAL_ADDR, PAL_WRITEDATA);
      end else begin
        mon_e = exp_q.pop_front();
        if ({PAL_ADDR, PAL_WRITEDATA} !== mon_e) begin
          errors++;
          $display("FAIL eng_write: addr=%0d data=%08h required addr=%0d data=%08h",
                   PAL_ADDR, PAL_WRITEDATA, mon_e[36:32], mon_e[31:0]);
        end
      end
      if (CPU_WRITE) begin
        checks++;
        if (CPU_WAITREQUEST !== 1'b1) begin
          errors++;
          $display("FAIL eng_write_waitreq: got %b required 1", CPU_WAITREQUEST);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] fade(input logic [31:0] v, input logic [7:0] s);
    logic [31:0] r;
    r = 32'h0;
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = (v[c*8 +: 8] > s) ? v[c*8 +: 8] - s : 8'h00;
    return r;
  endfunction

  task automatic push_pass(input logic [2:0] sel, input logic [7:0] step);
    for (int i = 0; i < 4; i++) begin
      logic [4:0] a;
      a = {sel, 2'(i)};
      model[a] = fade(model[a], step);
      exp_q.push_back({a, model[a]});
    end
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge CLK_100);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
    @(negedge CLK_100);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge CLK_100);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(negedge CLK_100);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    d = AVL_READDATA;
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge CLK_100);
    CPU_ADDR = a; CPU_WRITEDATA = d; CPU_BYTE_EN = 4'hF; CPU_WRITE = 1'b1;
    #1;
    while (CPU_WAITREQUEST && n < 100) begin @(negedge CLK_100); #1; n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL cpu_write_timeout: waitrequest=%b required 0", CPU_WAITREQUEST);
    end
    @(negedge CLK_100);
    CPU_WRITE = 1'b0;
    model[a] = d;
  endtask

  task automatic cpu_read(input logic [4:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge CLK_100);
    CPU_ADDR = a; CPU_READ = 1'b1;
    #1;
    while (CPU_WAITREQUEST && n < 100) begin @(negedge CLK_100); #1; n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL cpu_read_timeout: waitrequest=%b required 0", CPU_WAITREQUEST);
    end
    @(negedge CLK_100);
    CPU_READ = 1'b0;
    d = CPU_READDATA;
  endtask

  task automatic vsync_pulse();
    @(negedge CLK_100); VSYNC = 1'b1;
    @(negedge CLK_100); VSYNC = 1'b0;
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (eng_wr_cnt < target && n < 400) begin @(negedge CLK_100); #1; n++; end
    checks++;
    if (eng_wr_cnt < target) begin
      errors++;
      $display("FAIL wait_writes_timeout: writes=%0d required %0d", eng_wr_cnt, target);
    end
  endtask

  task automatic wait_eng_read(input logic [4:0] a, output int at);
    int n = 0;
    at = -1;
    while (n < 200) begin
      @(negedge CLK_100); #1; n++;
      if (PAL_READ && !CPU_READ && PAL_ADDR == a) begin at = cyc; break; end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL wait_eng_read_timeout: no engine read of addr %0d", a);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(negedge CLK_100);
    checks++; if (AVL_READDATA !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %08h required 0", AVL_READDATA); end
    checks++; if (CPU_WAITREQUEST !== 1'b0) begin errors++; $display("FAIL rst_waitreq: got %b required 0", CPU_WAITREQUEST); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b required 0", IRQ); end
    checks++; if ({PAL_WRITE, PAL_READ, PAL_CS} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b required 000", {PAL_WRITE, PAL_READ, PAL_CS}); end
    RESET = 1'b0;
    csr_read(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %08h required 0", d); end
    csr_read(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_frames: got %08h required 0", d); end
    csr_read(2'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %08h required 0", d); end
  endtask

  task automatic test_single_pass();
    logic [31:0] d;
    int rd_at, dur;
    cpu_write(5'd8, 32'h00FF8004);
    cpu_write(5'd9, 32'h00102030);
    cpu_write(5'd10, 32'h00808080);
    cpu_write(5'd11, 32'h00010203);
    csr_write(2'd1, 32'd1);
    csr_write(2'd0, 32'h0000_1009);
    push_pass(3'd2, 8'h10);
    vsync_pulse();
    wait_eng_read(5'd8, rd_at);
    wait_writes(eng_wr_cnt + 4);
    dur = wr_cycs[$] - rd_at + 1;
    checks++; if (dur != 12) begin errors++; $display("FAIL single_duration: got %0d cycles required 12", dur); end
    repeat (3) @(negedge CLK_100);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL single_irq: got %b required 1", IRQ); end
    csr_read(2'd2, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL single_status: got %08h required 00000002", d); end
    csr_read(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL single_frames: got %08h required 0", d); end
    cpu_read(5'd8, d);
    checks++; if (d !== 32'h00EF7000) begin errors++; $display("FAIL single_entry: got %08h required 00EF7000", d); end
    @(negedge CLK_100);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 2'd2; AVL_WRITEDATA = 32'h2;
    @(negedge CLK_100);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL clear_irq: got %b required 0", IRQ); end
    csr_read(2'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_status: got %08h required 0", d); end
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    logic [31:0] want [3];
    logic [31:0] st;
    want[0] = 32'h00000218; want[1] = 32'h00000010; want[2] = 32'h00000008;
    cpu_write(5'd4, 32'h00050A20);
    cpu_write(5'd5, 32'h00FFFFFF);
    cpu_write(5'd6, 32'h00000000);
    cpu_write(5'd7, 32'h00123456);
    csr_write(2'd1, 32'd3);
    csr_write(2'd0, 32'h0000_0805);
    for (int p = 0; p < 3; p++) begin
      push_pass(3'd1, 8'h08);
      vsync_pulse();
      wait_writes(eng_wr_cnt + 4);
      repeat (3) @(negedge CLK_100);
      cpu_read(5'd4, d);
      checks++; if (d !== want[p]) begin errors++; $display("FAIL sat_entry pass %0d: got %08h required %08h", p + 1, d, want[p]); end
      csr_read(2'd2, d);
      st = (p == 2) ? 32'h2 : 32'h0;
      checks++; if (d !== st) begin errors++; $display("FAIL sat_status pass %0d: got %08h required %08h", p + 1, d, st); end
    end
    csr_write(2'd2, 32'h2);
  endtask

  task automatic test_contention();
    logic [31:0] d;
    int n = 0, wq = 0, span, target;
    cpu_write(5'd12, 32'h00404040);
    cpu_write(5'd13, 32'h00000102);
    cpu_write(5'd14, 32'h00FF00FF);
    cpu_write(5'd15, 32'h00010101);
    csr_write(2'd1, 32'd1);
    csr_write(2'd0, 32'h0000_010D);
    push_pass(3'd3, 8'h01);
    target = eng_wr_cnt + 4;
    @(negedge CLK_100);
    CPU_ADDR = 5'd0; CPU_WRITEDATA = 32'hCAFE0123; CPU_BYTE_EN = 4'hF; CPU_WRITE = 1'b1;
    model[0] = 32'hCAFE0123;
    vsync_pulse();
    while (eng_wr_cnt < target && n < 300) begin
      @(negedge CLK_100); #1; n++;
      if (CPU_WAITREQUEST) wq++;
    end
    @(negedge CLK_100);
    CPU_WRITE = 1'b0;
    checks++; if (eng_wr_cnt < target) begin errors++; $display("FAIL cont_timeout: writes=%0d required %0d", eng_wr_cnt, target); end
    checks++; if (wq != 12) begin errors++; $display("FAIL cont_waitreq_cycles: got %0d required 12", wq); end
    span = (wr_cycs.size() >= 4) ? wr_cycs[$] - wr_cycs[$-3] : -1;
    checks++; if (span != 21) begin errors++; $display("FAIL cont_span: got %0d cycles required 21", span); end
    repeat (3) @(negedge CLK_100);
    cpu_read(5'd0, d);
    checks++; if (d !== 32'hCAFE0123) begin errors++; $display("FAIL cont_cpu_data: got %08h required CAFE0123", d); end
    cpu_read(5'd12, d);
    checks++; if (d !== 32'h003F3F3F) begin errors++; $display("FAIL cont_entry: got %08h required 003F3F3F", d); end
    csr_write(2'd2, 32'h2);
  endtask

  task automatic test_vsync_burst();
    logic [31:0] d;
    int rd_at, base;
    cpu_write(5'd16, 32'h00101010);
    cpu_write(5'd17, 32'h00202020);
    cpu_write(5'd18, 32'h00303030);
    cpu_write(5'd19, 32'h00404040);
    csr_write(2'd1, 32'd5);
    csr_write(2'd0, 32'h0000_0111);
    base = eng_wr_cnt;
    push_pass(3'd4, 8'h01);
    push_pass(3'd4, 8'h01);
    vsync_pulse();
    wait_eng_read(5'd16, rd_at);
    repeat (3) vsync_pulse();
    csr_read(2'd2, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL burst_status_busy: got %08h required 00000005", d); end
    wait_writes(base + 8);
    repeat (30) @(negedge CLK_100);
    checks++; if (eng_wr_cnt != base + 8) begin errors++; $display("FAIL burst_pass_count: got %0d writes required %0d", eng_wr_cnt - base, 8); end
    csr_read(2'd1, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL burst_frames: got %08h required 00000003", d); end
    csr_read(2'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL burst_status_idle: got %08h required 0", d); end
  endtask

  task automatic test_ctrl_shadow();
    logic [31:0] d;
    int rd_at, base;
    cpu_write(5'd20, 32'h00305070);
    cpu_write(5'd21, 32'h00FFFFFF);
    cpu_write(5'd22, 32'h00151515);
    cpu_write(5'd23, 32'h00252525);
    csr_write(2'd1, 32'd2);
    csr_write(2'd0, 32'h0000_1015);
    base = eng_wr_cnt;
    push_pass(3'd5, 8'h10);
    vsync_pulse();
    wait_eng_read(5'd20, rd_at);
    csr_write(2'd0, 32'h0000_2015);
    push_pass(3'd5, 8'h20);
    wait_writes(base + 4);
    repeat (3) @(negedge CLK_100);
    cpu_read(5'd20, d);
    checks++; if (d !== 32'h00204060) begin errors++; $display("FAIL shadow_pass1: got %08h required 00204060", d); end
    vsync_pulse();
    wait_writes(base + 8);
    repeat (3) @(negedge CLK_100);
    cpu_read(5'd20, d);
    checks++; if (d !== 32'h00002040) begin errors++; $display("FAIL shadow_pass2: got %08h required 00002040", d); end
    csr_read(2'd0, d);
    checks++; if (d !== 32'h0000_2015) begin errors++; $display("FAIL shadow_ctrl: got %08h required 00002015", d); end
    csr_write(2'd2, 32'h2);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] keep [3];
    int rd_at, base;
    keep[0] = 32'h00222222; keep[1] = 32'h00333333; keep[2] = 32'h00444444;
    cpu_write(5'd24, 32'h00111111);
    cpu_write(5'd25, keep[0]);
    cpu_write(5'd26, keep[1]);
    cpu_write(5'd27, keep[2]);
    csr_write(2'd1, 32'd1);
    csr_write(2'd0, 32'h0000_0119);
    csr_read(2'd0, d);
    base = eng_wr_cnt;
    model[24] = fade(model[24], 8'h01);
    exp_q.push_back({5'd24, model[24]});
    vsync_pulse();
    wait_eng_read(5'd25, rd_at);
    @(posedge CLK_100);
    #2 RESET = 1'b1;
    #1;
    checks++; if ({PAL_WRITE, PAL_READ, PAL_CS} !== 3'b000) begin errors++; $display("FAIL mid_rst_strobes: got %b required 000", {PAL_WRITE, PAL_READ, PAL_CS}); end
    checks++; if (CPU_WAITREQUEST !== 1'b0) begin errors++; $display("FAIL mid_rst_waitreq: got %b required 0", CPU_WAITREQUEST); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL mid_rst_irq: got %b required 0", IRQ); end
    checks++; if (AVL_READDATA !== 32'h0) begin errors++; $display("FAIL mid_rst_readdata: got %08h required 0", AVL_READDATA); end
    repeat (3) @(negedge CLK_100);
    RESET = 1'b0;
    repeat (20) @(negedge CLK_100);
    checks++; if (eng_wr_cnt != base + 1) begin errors++; $display("FAIL mid_rst_writes: got %0d required 1", eng_wr_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      cpu_read(5'(25 + i), d);
      checks++; if (d !== keep[i]) begin errors++; $display("FAIL mid_rst_entry %0d: got %08h required %08h", 25 + i, d, keep[i]); end
    end
    csr_read(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_ctrl: got %08h required 0", d); end
    csr_read(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_frames: got %08h required 0", d); end
  endtask

  initial begin
    AVL_ADDR = 2'd0; AVL_WRITEDATA = 32'h0; AVL_WRITE = 1'b0; AVL_READ = 1'b0; AVL_CS = 1'b0;
    CPU_ADDR = 5'd0; CPU_WRITEDATA = 32'h0; CPU_BYTE_EN = 4'hF; CPU_WRITE = 1'b0; CPU_READ = 1'b0;
    VSYNC = 1'b0;
    test_reset();
    test_single_pass();
    test_saturation();
    test_contention();
    test_vsync_burst();
    test_ctrl_shadow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
